// File: rtl/pipeline_data_mem_if.sv
// CPU-side data bus of the Mem stage: address, store data and strobe out, load data back.
interface pipeline_data_mem_if;
  logic        mem_we;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_out;

  modport master (output mem_we, output addr_in, output wdata_in, input rdata_out);
  modport slave  (input mem_we, input addr_in, input wdata_in, output rdata_out);
endinterface

// File: rtl/pipeline_data_mem.sv
// Mem-stage data memory: word RAM with combinational read plus an MMIO window
// (LED register, free-running cycle counter, RAM store counter).
module pipeline_data_mem #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000,
  parameter              INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_data_mem_if.slave  bus,
  output logic [15:0]         led_out,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         store_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           ram [DEPTH];
  logic                  is_mmio;
  logic [1:0]            offset;
  logic [ADDR_WIDTH-1:0] index;
  logic                  ram_we;
  logic                  led_we;
  logic                  cycle_clr;
  logic [15:0]           led_q;
  logic [31:0]           cycle_q;
  logic [31:0]           store_q;
  logic                  unused_addr;

  // Byte lane bits are meaningless for word-only access; bits above the index alias.
  assign unused_addr = ^bus.addr_in[1:0];

  assign is_mmio   = (bus.addr_in[31:4] == MMIO_BASE[31:4]);
  assign offset    = bus.addr_in[3:2];
  assign index     = bus.addr_in[ADDR_WIDTH+1:2];
  assign ram_we    = bus.mem_we && !is_mmio;
  assign led_we    = bus.mem_we && is_mmio && (offset == 2'd0);
  assign cycle_clr = bus.mem_we && is_mmio && (offset == 2'd1);

  always_comb begin
    bus.rdata_out = 32'h0;
    if (is_mmio) begin
      case (offset)
        2'd0:    bus.rdata_out = {16'h0, led_q};
        2'd1:    bus.rdata_out = cycle_q;
        2'd2:    bus.rdata_out = store_q;
        default: bus.rdata_out = 32'h0;
      endcase
    end else begin
      bus.rdata_out = ram[index];
    end
  end

  // RAM has no reset: its contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[index] <= bus.wdata_in;
    end
  end

  // A CYCLE write on the same edge takes priority over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= 16'h0;
      cycle_q <= 32'h0;
      store_q <= 32'h0;
    end else begin
      cycle_q <= cycle_clr ? 32'h0 : cycle_q + 32'd1;
      if (led_we) begin
        led_q <= bus.wdata_in[15:0];
      end
      if (ram_we) begin
        store_q <= store_q + 32'd1;
      end
    end
  end

  assign led_out   = led_q;
  assign cycle_cnt = cycle_q;
  assign store_cnt = store_q;

endmodule
